// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port: instruction fetch and load/store.
// One transaction outstanding; response is a single-cycle pulse routed to the owner.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int DATA_PRIO = 1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              inst_req_valid,
    output logic              inst_req_ready,
    input  logic [ADDR_W-1:0] inst_req_addr,
    output logic              inst_resp_valid,
    output logic [DATA_W-1:0] inst_resp_data,

    input  logic              data_req_valid,
    output logic              data_req_ready,
    input  logic              data_req_write,
    input  logic [ADDR_W-1:0] data_req_addr,
    input  logic [DATA_W-1:0] data_req_wdata,
    input  logic [3:0]        data_req_mark,
    output logic              data_resp_valid,
    output logic [DATA_W-1:0] data_resp_data,

    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [3:0]        mem_mark,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner;
    logic             is_write;
    logic             last_grant;
    logic [LAT_W-1:0] lat_cnt;

    logic grant_data;
    logic accept;
    logic resp_fire;
    logic grant_write;

    // Tie-break: fixed data priority, or alternate away from the previous winner.
    always_comb begin
        grant_data = data_req_valid;
        if (data_req_valid && inst_req_valid) begin
            grant_data = (DATA_PRIO != 0) ? 1'b1 : !last_grant;
        end
    end

    assign accept      = (state == IDLE) && !reset && (inst_req_valid || data_req_valid);
    assign grant_write = grant_data && data_req_write;
    assign resp_fire   = (state == BUSY) && !reset && (lat_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            is_write   <= 1'b0;
            last_grant <= 1'b1;
            lat_cnt    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner      <= grant_data;
                is_write   <= grant_write;
                last_grant <= grant_data;
                lat_cnt    <= LAT_INIT;
            end else if ((state == BUSY) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
        end
    end

    always_comb begin
        state_next      = state;
        inst_req_ready  = 1'b0;
        data_req_ready  = 1'b0;
        inst_resp_valid = 1'b0;
        inst_resp_data  = '0;
        data_resp_valid = 1'b0;
        data_resp_data  = '0;
        mem_read_en     = 1'b0;
        mem_write_en    = 1'b0;
        mem_mark        = '0;
        mem_addr        = '0;
        mem_write_data  = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next     = BUSY;
                    inst_req_ready = !grant_data;
                    data_req_ready = grant_data;
                    mem_read_en    = !grant_write;
                    mem_write_en   = grant_write;
                    mem_mark       = grant_write ? data_req_mark : 4'hF;
                    mem_addr       = grant_data ? data_req_addr : inst_req_addr;
                    mem_write_data = grant_write ? data_req_wdata : '0;
                end
            end
            BUSY: begin
                if (lat_cnt == '0) begin
                    state_next = IDLE;
                end
                if (resp_fire) begin
                    if (owner) begin
                        data_resp_valid = 1'b1;
                        data_resp_data  = is_write ? '0 : mem_read_data;
                    end else begin
                        inst_resp_valid = 1'b1;
                        inst_resp_data  = mem_read_data;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
